// File: rtl/cc_pkg.sv
// Shared condition-code types, constants and helpers for the LC-3
// N/Z/P flag and branch-enable logic.
package cc_pkg;

   typedef logic [2:0] nzp_t;

   localparam nzp_t NZP_N     = 3'b100;
   localparam nzp_t NZP_Z     = 3'b010;
   localparam nzp_t NZP_P     = 3'b001;
   localparam nzp_t NZP_RESET = NZP_Z;

   // Width of a context index; a single-context unit still gets a 1-bit select.
   function automatic int ctx_width(input int num_ctx);
      return (num_ctx > 1) ? $clog2(num_ctx) : 1;
   endfunction

   // A BRnzp mask is taken when any selected condition matches the flags.
   function automatic logic nzp_taken(input nzp_t mask, input nzp_t flags);
      return |(mask & flags);
   endfunction

endpackage

// File: rtl/cc_classify.sv
// Combinational N/Z/P classifier for a WIDTH-bit bus value; the result is
// always exactly one-hot.
module cc_classify
   import cc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] bus_in,
   output nzp_t             nzp
);

   // NOTE: every branch assigns nzp, so no latch can be inferred.
   always_comb begin
      if (bus_in == '0) begin
         nzp = NZP_Z;
      end else if (bus_in[WIDTH-1]) begin
         nzp = NZP_N;
      end else begin
         nzp = NZP_P;
      end
   end

endmodule

// File: rtl/cc_ben_unit.sv
// Multi-context condition-code and branch-enable unit: per-context NZP flags,
// registered BEN with a valid strobe, and saturating branch statistics.
module cc_ben_unit
   import cc_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NUM_CTX = 4,
   parameter int FWD     = 1,
   parameter int CNT_W   = 8,
   parameter int CTX_W   = ctx_width(NUM_CTX)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LD_CC,
   input  logic             LD_BEN,
   input  logic [CTX_W-1:0] ctx_sel,
   input  logic [2:0]       IR,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             clr_stats,
   input  logic [CTX_W-1:0] stat_sel,
   output logic             BEN,
   output logic             ben_valid,
   output logic [2:0]       nzp_out,
   output logic [CNT_W-1:0] eval_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   nzp_t             flags     [NUM_CTX];
   logic [CNT_W-1:0] eval_cnt  [NUM_CTX];
   logic [CNT_W-1:0] taken_cnt [NUM_CTX];

   nzp_t bus_nzp;
   nzp_t cur_flags;
   nzp_t eval_flags;
   logic ctx_ok;
   logic stat_ok;
   logic do_cc;
   logic do_ben;
   logic ben_next;

   cc_classify #(.WIDTH(WIDTH)) u_classify (
      .bus_in (bus_in),
      .nzp    (bus_nzp)
   );

   // A non-power-of-2 context count leaves select codes with no storage behind them.
   assign ctx_ok  = (int'(ctx_sel)  < NUM_CTX);
   assign stat_ok = (int'(stat_sel) < NUM_CTX);
   assign do_cc   = LD_CC  && ctx_ok;
   assign do_ben  = LD_BEN && ctx_ok;

   always_comb begin
      cur_flags = NZP_RESET;
      if (ctx_ok) begin
         cur_flags = flags[ctx_sel];
      end
   end

   // With forwarding, a simultaneous flag load is visible to the branch evaluation.
   assign eval_flags = ((FWD != 0) && do_cc) ? bus_nzp : cur_flags;
   assign ben_next   = nzp_taken(nzp_t'(IR), eval_flags);

   // NOTE: registered state is written only with non-blocking assignments.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         // NOTE: the flag and counter arrays are tiny and must start known, so they are reset.
         for (int i = 0; i < NUM_CTX; i++) begin
            flags[i] <= NZP_RESET;
         end
         BEN       <= 1'b0;
         ben_valid <= 1'b0;
      end else begin
         ben_valid <= 1'b0;
         if (do_cc) begin
            flags[ctx_sel] <= bus_nzp;
         end
         if (do_ben) begin
            BEN       <= ben_next;
            ben_valid <= 1'b1;
         end
      end
   end

   // Clear beats a same-cycle evaluation; counters stick at all-ones.
   always_ff @(posedge Clk) begin
      if (Reset || clr_stats) begin
         for (int i = 0; i < NUM_CTX; i++) begin
            eval_cnt[i]  <= '0;
            taken_cnt[i] <= '0;
         end
      end else if (do_ben) begin
         if (eval_cnt[ctx_sel] != CNT_MAX) begin
            eval_cnt[ctx_sel] <= eval_cnt[ctx_sel] + 1'b1;
         end
         if (ben_next && (taken_cnt[ctx_sel] != CNT_MAX)) begin
            taken_cnt[ctx_sel] <= taken_cnt[ctx_sel] + 1'b1;
         end
      end
   end

   always_comb begin
      nzp_out     = '0;
      eval_count  = '0;
      taken_count = '0;
      if (stat_ok) begin
         nzp_out     = flags[stat_sel];
         eval_count  = eval_cnt[stat_sel];
         taken_count = taken_cnt[stat_sel];
      end
   end

endmodule

// File: tb/tb_cc_ben_unit.sv
// Directed bench for cc_ben_unit: two instances (forwarding/4 contexts/4-bit
// counters and no-forwarding/3 contexts/8-bit counters) against a scoreboard.
module tb_cc_ben_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        LD_CC;
   logic        LD_BEN;
   logic [1:0]  ctx_sel;
   logic [2:0]  IR;
   logic [15:0] bus_in;
   logic        clr_stats;
   logic [1:0]  stat_sel;

   logic        ben_a, vld_a, ben_b, vld_b;
   logic [2:0]  nzp_a, nzp_b;
   logic [3:0]  ev_a, tk_a;
   logic [7:0]  ev_b, tk_b;

   int errors = 0;
   int checks = 0;

   // Model state, index 0 = instance a, 1 = instance b.
   localparam int NC  [2] = '{4, 3};
   localparam int FW  [2] = '{1, 0};
   localparam int CMX [2] = '{15, 255};
   logic [2:0] m_flags [2][4];
   int         m_eval  [2][4];
   int         m_taken [2][4];
   logic       m_ben   [2];
   logic       m_vld   [2];
   logic       q_a[$];
   logic       q_b[$];

   always #5 Clk = ~Clk;

   cc_ben_unit #(.WIDTH(16), .NUM_CTX(4), .FWD(1), .CNT_W(4)) u_a (
      .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .ctx_sel(ctx_sel),
      .IR(IR), .bus_in(bus_in), .clr_stats(clr_stats), .stat_sel(stat_sel),
      .BEN(ben_a), .ben_valid(vld_a), .nzp_out(nzp_a),
      .eval_count(ev_a), .taken_count(tk_a)
   );

   cc_ben_unit #(.WIDTH(16), .NUM_CTX(3), .FWD(0), .CNT_W(8)) u_b (
      .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .ctx_sel(ctx_sel),
      .IR(IR), .bus_in(bus_in), .clr_stats(clr_stats), .stat_sel(stat_sel),
      .BEN(ben_b), .ben_valid(vld_b), .nzp_out(nzp_b),
      .eval_count(ev_b), .taken_count(tk_b)
   );

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] cls(input logic [15:0] v);
      if (v == 16'h0000) return 3'b010;
      return v[15] ? 3'b100 : 3'b001;
   endfunction

   task automatic model(input logic rst, cc, ben, clr, input logic [1:0] ctx,
                        input logic [2:0] ir, input logic [15:0] bus);
      for (int d = 0; d < 2; d++) begin
         logic       ok, exp;
         logic [2:0] f;
         m_vld[d] = 1'b0;
         if (rst) begin
            for (int c = 0; c < 4; c++) begin
               m_flags[d][c] = 3'b010;
               m_eval[d][c]  = 0;
               m_taken[d][c] = 0;
            end
            m_ben[d] = 1'b0;
            continue;
         end
         ok  = (int'(ctx) < NC[d]);
         f   = (FW[d] != 0 && cc && ok) ? cls(bus) : m_flags[d][ctx];
         exp = |(ir & f);
         if (ben && ok) begin
            m_ben[d] = exp;
            m_vld[d] = 1'b1;
            if (d == 0) q_a.push_back(exp);
            else        q_b.push_back(exp);
         end
         if (cc && ok) m_flags[d][ctx] = cls(bus);
         if (clr) begin
            for (int c = 0; c < 4; c++) begin
               m_eval[d][c]  = 0;
               m_taken[d][c] = 0;
            end
         end else if (ben && ok) begin
            if (m_eval[d][ctx] < CMX[d]) m_eval[d][ctx]++;
            if (exp && m_taken[d][ctx] < CMX[d]) m_taken[d][ctx]++;
         end
      end
   endtask

   // Drive one cycle of stimulus at the falling edge, check just after the rising edge.
   task automatic step(input logic rst, cc, ben, clr, input logic [1:0] ctx,
                       input logic [2:0] ir, input logic [15:0] bus);
      logic e;
      Reset = rst; LD_CC = cc; LD_BEN = ben; clr_stats = clr;
      ctx_sel = ctx; IR = ir; bus_in = bus;
      model(rst, cc, ben, clr, ctx, ir, bus);
      @(posedge Clk);
      #1;
      check("a_valid", vld_a, m_vld[0]);
      if (vld_a) begin
         if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
         else begin e = q_a.pop_front(); check("a_ben", ben_a, e); end
      end
      check("a_ben_hold", ben_a, m_ben[0]);
      check("b_valid", vld_b, m_vld[1]);
      if (vld_b) begin
         if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
         else begin e = q_b.pop_front(); check("b_ben", ben_b, e); end
      end
      check("b_ben_hold", ben_b, m_ben[1]);
      @(negedge Clk);
      Reset = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0; clr_stats = 1'b0;
   endtask

   task automatic check_stats();
      for (int s = 0; s < 4; s++) begin
         stat_sel = 2'(s);
         #1;
         check($sformatf("a_nzp%0d", s),   nzp_a, m_flags[0][s]);
         check($sformatf("a_eval%0d", s),  ev_a,  m_eval[0][s]);
         check($sformatf("a_taken%0d", s), tk_a,  m_taken[0][s]);
         check($sformatf("b_nzp%0d", s),   nzp_b, (s < NC[1]) ? m_flags[1][s] : 3'b000);
         check($sformatf("b_eval%0d", s),  ev_b,  (s < NC[1]) ? m_eval[1][s] : 0);
         check($sformatf("b_taken%0d", s), tk_b,  (s < NC[1]) ? m_taken[1][s] : 0);
      end
   endtask

   initial begin
      logic [15:0] vals [3];
      vals = '{16'h0000, 16'h8000, 16'h1234};
      Reset = 1'b1; LD_CC = 1'b0; LD_BEN = 1'b0; clr_stats = 1'b0;
      ctx_sel = '0; IR = '0; bus_in = '0; stat_sel = '0;
      @(negedge Clk);

      // Reset state.
      step(1, 0, 0, 0, 2'd0, 3'b000, 16'h0000);
      step(1, 0, 0, 0, 2'd0, 3'b000, 16'h0000);
      check_stats();
      check("reset_ben", ben_a, 1'b0);

      // Negative value on ctx 1, then two masks.
      step(0, 1, 0, 0, 2'd1, 3'b000, 16'h8000);
      step(0, 0, 1, 0, 2'd1, 3'b100, 16'h0000);
      check("neg_taken", ben_a, 1'b1);
      step(0, 0, 1, 0, 2'd1, 3'b011, 16'h0000);
      check("neg_not_taken", ben_a, 1'b0);
      step(0, 0, 0, 0, 2'd0, 3'b000, 16'h0000);
      check_stats();

      // Same-cycle load and evaluate: forwarding differs, next cycle agrees.
      step(0, 1, 1, 0, 2'd2, 3'b001, 16'h0005);
      check("fwd1_ben", ben_a, 1'b1);
      check("fwd0_ben", ben_b, 1'b0);
      step(0, 0, 1, 0, 2'd2, 3'b001, 16'h0000);
      check("next_cycle_a", ben_a, 1'b1);
      check("next_cycle_b", ben_b, 1'b1);

      // Saturation on ctx 3 (out of range on instance b).
      step(0, 1, 0, 0, 2'd3, 3'b000, 16'h0001);
      for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 2'd3, 3'b001, 16'h0000);
      stat_sel = 2'd3;
      #1;
      check("sat_eval", ev_a, 4'd15);
      check("sat_taken", tk_a, 4'd15);
      check_stats();

      // Clear wins over a same-cycle evaluation.
      step(0, 0, 1, 1, 2'd0, 3'b010, 16'h0000);
      check("clr_ben", ben_a, 1'b1);
      check_stats();
      step(0, 0, 1, 0, 2'd0, 3'b100, 16'h0000);
      step(0, 0, 1, 0, 2'd0, 3'b010, 16'h0000);
      check_stats();

      // Reset overrides loads and evaluations in the same cycle.
      step(1, 1, 1, 0, 2'd1, 3'b100, 16'h8000);
      check("rst_valid", vld_a, 1'b0);
      check_stats();

      // Mask 000 and 111 over all flag values.
      for (int v = 0; v < 3; v++) begin
         step(0, 1, 0, 0, 2'd0, 3'b000, vals[v]);
         step(0, 0, 1, 0, 2'd0, 3'b000, 16'h0000);
         check("mask000", ben_a, 1'b0);
         step(0, 0, 1, 0, 2'd0, 3'b111, 16'h0000);
         check("mask111", ben_a, 1'b1);
      end

      // Mixed traffic.
      for (int i = 0; i < 40; i++) begin
         step(0, 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
              2'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
      end
      check_stats();

      check("queue_a_empty", q_a.size(), 0);
      check("queue_b_empty", q_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
